// File: rtl/uart_mem_pkg.sv
// Shared command codes, ACK byte and state encodings for the UART-to-memory bridge.
package uart_mem_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE  = 8'h06;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, WAIT, RESP} state_e;

    typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/uart_bridge_phy.sv
// 8N1 UART bit engine: synchronised mid-bit RX sampling with framing-error strobe,
// and a TX serialiser that can take the next byte on the last stop-bit cycle.
module uart_bridge_phy
    import uart_mem_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       rx_frame_err_o,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic [2:0]  rx_sync_q, rx_sync_d;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_err_q, rx_err_d;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;

    logic rx_s, rx_prev;

    // Sync chain resets low so a line held low across reset never looks like idle.
    assign rx_s    = rx_sync_q[1];
    assign rx_prev = rx_sync_q[2];

    always_comb begin
        rx_sync_d  = {rx_sync_q[1:0], rx_i};
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        unique case (rx_state_q)
            RX_ARM: begin
                rx_cnt_d = '0;
                if (rx_s) rx_state_d = RX_IDLE;
            end
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_s) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rx_s;
                    rx_err_d   = !rx_s;
                end
            end
            default: rx_state_d = RX_ARM;
        endcase
    end

    assign tx_ready_o = (tx_state_q == TX_IDLE) ||
                        ((tx_state_q == TX_STOP) && (tx_cnt_q == BIT_LAST));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
        endcase
        // Accepting on the last stop cycle starts the next start bit with no gap.
        if (tx_valid_i && tx_ready_o) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_data_i;
            tx_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync_q  <= '0;
            rx_state_q <= RX_ARM;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_o           = tx_q;
    assign rx_valid_o     = rx_valid_q;
    assign rx_data_o      = rx_shift_q;
    assign rx_frame_err_o = rx_err_q;

endmodule

// File: rtl/uart_mem_bridge.sv
// UART host frames (write 0x57 / read 0x52) translated into single memory
// request/grant/rvalid transactions, with ACK or read data returned over TX.
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [11:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic        uart_recv_error
);

    logic       rx_valid, rx_frame_err, tx_ready;
    logic [7:0] rx_data;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        req_q, req_d;
    logic [3:0]  be_q, be_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        resp_go;

    uart_bridge_phy #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_phy (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rx_i           (rx_i),
        .tx_o           (tx_o),
        .rx_valid_o     (rx_valid),
        .rx_data_o      (rx_data),
        .rx_frame_err_o (rx_frame_err),
        .tx_valid_i     (tx_valid_q),
        .tx_data_i      (tx_data_q),
        .tx_ready_o     (tx_ready)
    );

    assign resp_go = ((state_q == REQ) && data_gnt_i && data_rvalid_i) ||
                     ((state_q == WAIT) && data_rvalid_i);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        req_d      = req_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        state_d = ADDR;
                        we_d    = (rx_data == CMD_WRITE);
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    if (cnt_q == 2'd0) begin
                        addr_d[11:8] = rx_data[3:0];
                        cnt_d        = 2'd1;
                    end else begin
                        addr_d[7:0] = rx_data;
                        cnt_d       = '0;
                        if (we_q) begin
                            state_d = DATA;
                        end else begin
                            state_d = REQ;
                            req_d   = 1'b1;
                            be_d    = '1;
                        end
                    end
                end
            end
            DATA: begin
                if (rx_valid) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        be_d    = '1;
                    end
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    req_d   = 1'b0;
                    be_d    = '0;
                    state_d = WAIT;
                end
            end
            WAIT: ;
            RESP: begin
                if (tx_valid_q && tx_ready) begin
                    if (we_q || cnt_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d     = cnt_q + 2'd1;
                        tx_data_d = 8'(rdata_q >> {cnt_q + 2'd1, 3'b000});
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Grant+rvalid in one cycle skips WAIT; read data is taken straight from the bus.
        if (resp_go) begin
            state_d    = RESP;
            cnt_d      = '0;
            tx_valid_d = 1'b1;
            tx_data_d  = we_q ? ACK_BYTE : data_rdata_i[7:0];
            if (!we_q) rdata_d = data_rdata_i;
        end

        if (rx_frame_err) begin
            err_d = 1'b1;
            if (state_q == ADDR || state_q == DATA) state_d = IDLE;
        end
        if (rx_valid && (state_q == REQ || state_q == WAIT || state_q == RESP)) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            req_q      <= req_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign data_req_o      = req_q;
    assign data_we_o       = we_q;
    assign data_be_o       = be_q;
    assign data_addr_o     = addr_q;
    assign data_wdata_o    = wdata_q;
    assign uart_recv_error = err_q;

endmodule

// File: doc/uart_mem_bridge.md
UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

Interface
REQ-001: The module SHALL provide parameter CLKS_PER_BIT, default 16, defining clocks per UART bit (legal range 4..65535).
REQ-002: The module SHALL provide port clk_i, input, 1 bit, the single clock.
REQ-003: The module SHALL provide port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-004: The module SHALL provide port rx_i, input, 1 bit, UART serial in from the host-side controller.
REQ-005: The module SHALL provide port tx_o, output, 1 bit, UART serial out to the host-side controller.
REQ-006: The module SHALL provide port data_req_o, output, 1 bit, memory request.
REQ-007: The module SHALL provide port data_gnt_i, input, 1 bit, memory grant.
REQ-008: The module SHALL provide port data_rvalid_i, input, 1 bit, response valid, for reads and writes.
REQ-009: The module SHALL provide port data_we_o, output, 1 bit, write enable.
REQ-010: The module SHALL provide port data_be_o, output, 4 bits, byte enables.
REQ-011: The module SHALL provide port data_addr_o, output, 12 bits, word address.
REQ-012: The module SHALL provide port data_wdata_o, output, 32 bits, write data.
REQ-013: The module SHALL provide port data_rdata_i, input, 32 bits, read data.
REQ-014: The module SHALL provide port uart_recv_error, output, 1 bit, sticky receive error flag.

Function
REQ-015: The UART format SHALL be 8N1, LSB first, with an idle-high line.
REQ-016: RX SHALL detect a start bit on a falling edge, confirm it low at CLKS_PER_BIT/2, then sample each data bit and the stop bit at mid-bit.
REQ-017: A start bit that is high at the half-bit check SHALL be discarded silently, returning RX to idle.
REQ-018: The host frame SHALL be one command byte (0x57 write, 0x52 read), then addr_hi, then addr_lo, with data_addr_o = {addr_hi[3:0], addr_lo} and addr_hi[7:4] ignored.
REQ-019: A write frame SHALL carry 4 further bytes of write data, LSB first.
REQ-020: The FSM SHALL use states IDLE, ADDR, DATA, REQ, WAIT, RESP.
REQ-021: IDLE SHALL go to ADDR on a valid command byte.
REQ-022: IDLE SHALL stay in IDLE on any other command byte and set uart_recv_error.
REQ-023: ADDR SHALL go to DATA (write) or REQ (read) after 2 bytes; DATA SHALL go to REQ after 4 bytes.
REQ-024: REQ SHALL assert data_req_o starting the cycle after the final frame byte is accepted.
REQ-025: data_req_o, data_we_o, data_addr_o, data_wdata_o and data_be_o = 4'hF SHALL be held stable until data_gnt_i is sampled high.
REQ-026: data_req_o SHALL drop the cycle after the grant, with the FSM moving to WAIT.
REQ-027: If grant and rvalid arrive in the same cycle, the module SHALL accept both and go to RESP.
REQ-028: WAIT SHALL go to RESP on data_rvalid_i; on a read, data_rdata_i SHALL be captured in that cycle.
REQ-029: RESP SHALL transmit 0x06 for a write, or 4 bytes of captured read data LSB first for a read, then return to IDLE.
REQ-030: Back-to-back TX bytes SHALL have no idle gap beyond the stop bit.
REQ-031: A stop bit sampled low SHALL set uart_recv_error, discard the byte, and return the FSM to IDLE if it is mid-frame.
REQ-032: Any byte completed while in REQ, WAIT or RESP SHALL be discarded and set uart_recv_error (overrun); the transaction in progress SHALL complete normally.
REQ-033: uart_recv_error SHALL clear on acceptance of the next valid command byte.

Reset
REQ-034: On rst_ni low, all outputs SHALL go asynchronously to reset values: tx_o=1, data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0, uart_recv_error=0.
REQ-035: On rst_ni low, the FSM SHALL return to IDLE and RX/TX SHALL return to idle, abandoning any partial frame or transmission.
REQ-036: After reset release, RX SHALL require the line to be high before arming start detection.

Structure
REQ-037: The command codes (0x57, 0x52), the ACK code 0x06, and the FSM state enum SHALL live in shared package uart_mem_pkg.
REQ-038: Bit timing, RX sampling and TX serialisation SHALL live in one sub-module, uart_bridge_phy, with byte-valid/byte-ready handshakes and a framing-error strobe.

Verification
REQ-039: The bench SHALL cover a write: CLKS_PER_BIT=16, rx bytes 57 01 23 78 56 34 12, grant after 0 cycles -> one req with addr 0x123, wdata 0x12345678, we=1, be=F, then tx byte 06.
REQ-040: The bench SHALL cover a read: rx bytes 52 00 40, rdata 0xDEADBEEF with rvalid 2 cycles after grant -> addr 0x040, we=0, tx bytes EF BE AD DE.
REQ-041: The bench SHALL cover a stalled grant: read of 0x7FF with grant withheld for 5 cycles -> req and addr stable for 6 cycles, req low the cycle after grant.
REQ-042: The bench SHALL cover a bad command: rx 41 -> uart_recv_error=1, no req; a following valid read frame -> flag clears and the read completes.
REQ-043: The bench SHALL cover a framing error: write frame with the stop bit of byte 3 low -> uart_recv_error=1, no req, FSM in IDLE.
REQ-044: The bench SHALL cover reset mid-operation: rst_ni low during the third TX read-data byte -> tx_o=1 immediately, no further bytes sent, next frame serviced normally.
